modex_sequencer: RTL and testbench

MODEX_SEQUENCER -- requirements
Module: modex_sequencer

---
 rtl/modex_pkg.sv | 25 ++
 rtl/modex_sequencer_if.sv | 44 ++++
 rtl/modex_watchdog.sv | 29 ++
 rtl/modex_sequencer.sv | 143 ++++++++++++++
 tb/tb_modex_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/modex_pkg.sv
// Shared types and constants for the modular-exponentiation decryption sequencer.
// TIMEOUT_CYCLES is only consumed when MODEX_SEQ_TIMEOUT_EN is defined.
package modex_pkg;

  localparam int ARQ_DEF   = 16;
  localparam int ADDR_DEF  = 18;
  localparam int CNT_W_DEF = 10;

  localparam int TIMEOUT_CYCLES = 1 << 16;
  localparam int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LAUNCH,
    ST_WAIT,
    ST_STORE,
    ST_FINISH
  } seq_state_t;

  function automatic logic seq_is_active(input seq_state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/modex_sequencer_if.sv
// Bundle of control, memory, exponentiation and plaintext-buffer signals of the sequencer.
// The err line exists only when MODEX_SEQ_TIMEOUT_EN is defined.
interface modex_sequencer_if
  import modex_pkg::*;
#(
  parameter int ARQ   = ARQ_DEF,
  parameter int ADDR  = ADDR_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             start;
  logic [ADDR-1:0]  base_addr;
  logic [CNT_W-1:0] num_words;
  logic [ADDR-1:0]  mem_addr;
  logic             exp_start;
  logic             exp_done;
  logic [ARQ-1:0]   exp_result;
  logic             wr_en;
  logic [CNT_W-1:0] wr_addr;
  logic [ARQ-1:0]   wr_data;
  logic             busy;
  logic             done;
`ifdef MODEX_SEQ_TIMEOUT_EN
  logic             err;
`endif

  // master: the sequencer itself; slave: the surrounding system.
  modport master (
    input  start, base_addr, num_words, exp_done, exp_result,
    output mem_addr, exp_start, wr_en, wr_addr, wr_data, busy, done
`ifdef MODEX_SEQ_TIMEOUT_EN
    , output err
`endif
  );

  modport slave (
    output start, base_addr, num_words, exp_done, exp_result,
    input  mem_addr, exp_start, wr_en, wr_addr, wr_data, busy, done
`ifdef MODEX_SEQ_TIMEOUT_EN
    , input err
`endif
  );

endinterface

// File: rtl/modex_watchdog.sv
// WAIT-state watchdog: counts consecutive enabled cycles and flags the last allowed one.
// Compiled only when MODEX_SEQ_TIMEOUT_EN is defined.
`ifdef MODEX_SEQ_TIMEOUT_EN
module modex_watchdog
  import modex_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  output logic o_expired
);

  logic [TIMEOUT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (!i_enable) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // Asserted during the TIMEOUT_CYCLES-th consecutive enabled cycle.
  assign o_expired = i_enable && (r_count == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/modex_sequencer.sv
// Block-decryption sequencer: fetches ciphertext words, launches the exponentiator, stores results.
// Optional WAIT watchdog and sticky err flag enabled by MODEX_SEQ_TIMEOUT_EN.
module modex_sequencer
  import modex_pkg::*;
#(
  parameter int ARQ   = ARQ_DEF,
  parameter int ADDR  = ADDR_DEF,
  parameter int CNT_W = CNT_W_DEF
)(
  input  logic clk,
  input  logic rst,
  modex_sequencer_if.master bus
);

  seq_state_t       r_state;
  seq_state_t       w_state_next;
  logic [ADDR-1:0]  r_base;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_index;
  logic [ADDR-1:0]  r_mem_addr;
  logic [CNT_W-1:0] r_wr_addr;
  logic [ARQ-1:0]   r_wr_data;

  logic             w_accept;
  logic             w_exp_start;
  logic             w_wr_en;
  logic             w_done;
  logic             w_timeout;
  logic [CNT_W-1:0] w_index_inc;
  logic             w_last;

  assign w_index_inc = r_index + 1'b1;
  assign w_last      = (w_index_inc == r_num);

`ifdef MODEX_SEQ_TIMEOUT_EN
  logic r_err;

  modex_watchdog u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_enable  (r_state == ST_WAIT),
    .o_expired (w_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == ST_WAIT && !bus.exp_done && w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_exp_start  = 1'b0;
    w_wr_en      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = (bus.num_words != '0) ? ST_FETCH : ST_FINISH;
        end
      end
      ST_FETCH: w_state_next = ST_LAUNCH;
      ST_LAUNCH: begin
        w_exp_start  = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.exp_done) begin
          w_state_next = ST_STORE;
        end else if (w_timeout) begin
          w_state_next = ST_FINISH;
        end
      end
      ST_STORE: begin
        w_wr_en      = 1'b1;
        w_state_next = w_last ? ST_FINISH : ST_FETCH;
      end
      ST_FINISH: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base     <= '0;
      r_num      <= '0;
      r_index    <= '0;
      r_mem_addr <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      if (w_accept) begin
        r_base  <= bus.base_addr;
        r_num   <= bus.num_words;
        r_index <= '0;
        if (bus.num_words != '0) begin
          r_mem_addr <= bus.base_addr;
        end
      end
      if (r_state == ST_WAIT && bus.exp_done) begin
        r_wr_data <= bus.exp_result;
        r_wr_addr <= r_index;
      end
      // Next fetch address is computed here so FETCH sees a stable value; the add wraps.
      if (r_state == ST_STORE) begin
        r_index <= w_index_inc;
        if (!w_last) begin
          r_mem_addr <= r_base + ADDR'(w_index_inc);
        end
      end
    end
  end

  // busy covers the acceptance cycle itself, hence the combinational start term.
  assign bus.busy      = seq_is_active(r_state) | (w_accept & ~rst);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.exp_start = w_exp_start;
  assign bus.wr_en     = w_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.done      = w_done;

endmodule

// File: tb/tb_modex_sequencer.sv
// Scoreboard bench for modex_sequencer: expectations queued at stimulus, checked on DUT events.
// Exercises the watchdog scenario when MODEX_SEQ_TIMEOUT_EN is defined.
module tb_modex_sequencer;
  import modex_pkg::*;

  localparam int ARQ   = 16;
  localparam int ADDR  = 18;
  localparam int CNT_W = 10;

  typedef struct packed {
    logic [CNT_W-1:0] a;
    logic [ARQ-1:0]   d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  logic resp_done = 1'b0;
  logic stray_done = 1'b0;
  logic resp_en = 1'b1;

  logic [ADDR-1:0] q_addr[$];
  wr_t             q_wr[$];
  int              q_done[$];
  logic [ARQ-1:0]  q_res[$];

  modex_sequencer_if #(.ARQ(ARQ), .ADDR(ADDR), .CNT_W(CNT_W)) bus ();

  modex_sequencer #(.ARQ(ARQ), .ADDR(ADDR), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.exp_done = resp_done | stray_done;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    check_val({tag, "_exp_start"}, 32'(bus.exp_start), 0);
    check_val({tag, "_wr_en"}, 32'(bus.wr_en), 0);
    check_val({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    check_val({tag, "_wr_data"}, 32'(bus.wr_data), 0);
    check_val({tag, "_busy"}, 32'(bus.busy), 0);
    check_val({tag, "_done"}, 32'(bus.done), 0);
`ifdef MODEX_SEQ_TIMEOUT_EN
    check_val({tag, "_err"}, 32'(bus.err), 0);
`endif
  endtask

  // Exponentiator model: exp_done two cycles after each exp_start.
  initial begin
    bus.exp_result = '0;
    forever begin
      @(negedge clk);
      if (bus.exp_start && resp_en && !rst) begin
        repeat (2) @(posedge clk);
        #1;
        resp_done = 1'b1;
        bus.exp_result = (q_res.size() != 0) ? q_res.pop_front() : 16'hDEAD;
        @(posedge clk);
        #1;
        resp_done = 1'b0;
      end
    end
  end

  // Event monitor: each DUT transaction pops and checks its expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.exp_start) begin
        if (q_addr.size() == 0) check_val("unexpected_exp_start", 1, 0);
        else check_val("mem_addr", 32'(bus.mem_addr), 32'(q_addr.pop_front()));
        $display("launch cycle=%0d mem_addr=0x%05h", cyc, bus.mem_addr);
      end
      if (bus.wr_en) begin
        if (q_wr.size() == 0) begin
          check_val("unexpected_wr_en", 1, 0);
        end else begin
          wr_t w;
          w = q_wr.pop_front();
          check_val("wr_addr", 32'(bus.wr_addr), 32'(w.a));
          check_val("wr_data", 32'(bus.wr_data), 32'(w.d));
        end
        $display("write cycle=%0d wr_addr=%0d wr_data=0x%04h", cyc, bus.wr_addr, bus.wr_data);
      end
      if (bus.done) begin
        if (q_done.size() == 0) check_val("unexpected_done", 1, 0);
        else check_val("done_cycle", 32'(cyc), 32'(q_done.pop_front()));
        $display("done cycle=%0d", cyc);
      end
      if ((2'(bus.exp_start) + 2'(bus.wr_en) + 2'(bus.done)) > 2'd1)
        check_val("strobe_overlap", 32'(2'(bus.exp_start) + 2'(bus.wr_en) + 2'(bus.done)), 1);
    end
  end

  task automatic kick(input logic [ADDR-1:0] base, input logic [CNT_W-1:0] num, output int n);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.num_words = num;
    n = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Queue expectations for a run where every word takes 5 cycles (k=2), then start it.
  task automatic run_begin(input logic [ADDR-1:0] base, input logic [CNT_W-1:0] num,
                           input logic [ARQ-1:0] r0, input logic [ARQ-1:0] r1,
                           input logic [ARQ-1:0] r2);
    logic [ARQ-1:0] res[3];
    int n;
    res[0] = r0; res[1] = r1; res[2] = r2;
    for (int i = 0; i < int'(num); i++) begin
      logic [ADDR-1:0] a;
      a = ADDR'(int'(base) + i);
      q_addr.push_back(a);
      q_wr.push_back('{a: CNT_W'(i), d: res[i]});
      q_res.push_back(res[i]);
    end
    kick(base, num, n);
    q_done.push_back(n + 1 + 5 * int'(num));
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    if (i == budget) check_val("done_wait_expired", 0, 1);
    @(negedge clk);
    check_val("busy_after_done", 32'(bus.busy), 0);
  endtask

  task automatic wait_event_wr(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.wr_en) break;
    end
    if (i == budget) check_val("wr_wait_expired", 0, 1);
  endtask

  task automatic wait_event_launch(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.exp_start) break;
    end
    if (i == budget) check_val("launch_wait_expired", 0, 1);
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.num_words = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Three words from 0x10.
    run_begin(18'h00010, 10'd3, 16'h1111, 16'h2222, 16'h3333);
    wait_done(100);

    // Empty run: busy for the start cycle and the done cycle only.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.num_words = '0;
    n = cyc;
    q_done.push_back(n + 1);
    @(negedge clk);
    check_val("zero_busy_c1", 32'(bus.busy), 1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check_val("zero_busy_c2", 32'(bus.busy), 1);
    check_val("zero_done_c2", 32'(bus.done), 1);
    @(negedge clk);
    check_val("zero_busy_c3", 32'(bus.busy), 0);

    // Address wrap at the top of the ciphertext memory.
    run_begin(18'h3FFFF, 10'd2, 16'hA5A5, 16'h5A5A, 16'h0000);
    wait_done(100);

    // Stray start and exp_done during FETCH of the second word.
    run_begin(18'h00020, 10'd3, 16'h1111, 16'h2222, 16'h3333);
    wait_event_wr(50);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.base_addr = 18'h00100;
    bus.num_words = 10'd5;
    stray_done = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    stray_done = 1'b0;
    wait_done(100);

    // Reset during WAIT of the first word aborts without a done.
    q_addr.push_back(18'h00040);
    q_res.push_back(16'h7777);
    kick(18'h00040, 10'd2, n);
    wait_event_launch(20);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("midrun_reset");
    repeat (4) @(posedge clk);
    #1;
    q_res.delete();
    rst = 1'b0;
    run_begin(18'h00055, 10'd1, 16'hABCD, 16'h0000, 16'h0000);
    wait_done(100);

`ifdef MODEX_SEQ_TIMEOUT_EN
    // Exponentiator never answers: watchdog ends the run with err and no write.
    resp_en = 1'b0;
    check_val("err_before_timeout", 32'(bus.err), 0);
    q_addr.push_back(18'h00200);
    kick(18'h00200, 10'd1, n);
    q_done.push_back(n + 3 + TIMEOUT_CYCLES);
    wait_done(TIMEOUT_CYCLES + 100);
    check_val("err_after_timeout", 32'(bus.err), 1);
    @(negedge clk);
    check_val("err_sticky", 32'(bus.err), 1);
    resp_en = 1'b1;
`endif

    repeat (3) @(negedge clk);
    check_val("queues_drained", 32'(q_addr.size() + q_wr.size() + q_done.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
